// File: rtl/sha1_wb_master.sv
// Wishbone classic initiator running one SHA1 job: engine reset, 16 message writes, OPS polling, 5 digest reads.
// Optional SHA1_WBM_ID_CHECK_EN: read and verify the peripheral ID register before any write is issued.
module sha1_wb_master #(
  parameter logic [31:0] BASE_ADDRESS = 32'h30000024,
  parameter int          ACK_TIMEOUT  = 16,
  parameter int          POLL_MAX     = 1024
) (
  input  logic         wb_clk_i,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] message_in,
  output logic         busy,
  output logic         done,
  output logic [159:0] digest,
  output logic         error,
  output logic [1:0]   error_code,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  output logic         wbm_we_o,
  output logic [3:0]   wbm_sel_o,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  input  logic [31:0]  wbm_dat_i,
  input  logic         wbm_ack_i
);

  localparam logic [31:0] ADR_ID   = BASE_ADDRESS + 32'h4;
  localparam logic [31:0] ADR_OPS  = BASE_ADDRESS + 32'h8;
  localparam logic [31:0] ADR_MSG  = BASE_ADDRESS + 32'hC;
  localparam logic [31:0] ADR_DIG  = BASE_ADDRESS + 32'h10;
  localparam logic [31:0] ID_VALUE = 32'h53484131;
  localparam logic [31:0] EBUSY    = 32'hfffffff0;
  localparam int          TW       = $clog2(ACK_TIMEOUT + 1);
  localparam int          PW       = $clog2(POLL_MAX + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ID_RD, S_RST_WR, S_MSG_WR, S_POLL_RD, S_DIG_RD, S_FIN, S_ERR
  } state_t;

  state_t             r_state;
  logic [15:0][31:0]  r_msg;
  logic [4:0][31:0]   r_digest;
  logic [3:0]         r_idx;
  logic [PW-1:0]      r_polls;
  logic [TW-1:0]      r_tmo;
  logic               r_stb;
  logic               r_we;
  logic [31:0]        r_adr;
  logic [31:0]        r_dat;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic [1:0]         r_code;

  logic [31:0]        w_adr;
  logic               w_we;
  logic [31:0]        w_dat;
  logic               w_ack;
  logic [1:0]         w_fail_code;

  assign w_ack = r_stb & wbm_ack_i;

  // Next transaction for the current state, launched after the mandatory idle cycle.
  always_comb begin
    w_adr = ADR_OPS;
    w_we  = 1'b0;
    w_dat = 32'h0;
    case (r_state)
      S_ID_RD:  w_adr = ADR_ID;
      S_RST_WR: begin w_we = 1'b1; w_dat = 32'h2; end
      S_MSG_WR: begin w_adr = ADR_MSG; w_we = 1'b1; w_dat = r_msg[r_idx]; end
      S_DIG_RD: w_adr = ADR_DIG;
      default: ;
    endcase
  end

  always_comb begin
    w_fail_code = 2'd0;
    if (w_ack) begin
      case (r_state)
        S_ID_RD:   if (wbm_dat_i != ID_VALUE) w_fail_code = 2'd2;
        S_POLL_RD: begin
          if (wbm_dat_i[2])                               w_fail_code = 2'd2;
          else if (!wbm_dat_i[3] && r_polls == POLL_LAST) w_fail_code = 2'd3;
        end
        S_DIG_RD:  if (wbm_dat_i == EBUSY) w_fail_code = 2'd2;
        default: ;
      endcase
    end else if (r_stb && r_tmo == TMO_LAST) begin
      w_fail_code = 2'd1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_msg    <= '0;
      r_digest <= '0;
      r_idx    <= '0;
      r_polls  <= '0;
      r_tmo    <= '0;
      r_stb    <= 1'b0;
      r_we     <= 1'b0;
      r_adr    <= 32'h0;
      r_dat    <= 32'h0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_code   <= 2'd0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_msg    <= message_in;
            r_digest <= '0;
            r_code   <= 2'd0;
            r_busy   <= 1'b1;
            r_idx    <= '0;
            r_polls  <= '0;
            r_tmo    <= '0;
            r_stb    <= 1'b1;
`ifdef SHA1_WBM_ID_CHECK_EN
            r_state  <= S_ID_RD;
            r_adr    <= ADR_ID;
            r_we     <= 1'b0;
            r_dat    <= 32'h0;
`else
            r_state  <= S_RST_WR;
            r_adr    <= ADR_OPS;
            r_we     <= 1'b1;
            r_dat    <= 32'h2;
`endif
          end
        end
        S_FIN, S_ERR: r_state <= S_IDLE;
        default: begin
          if (w_fail_code != 2'd0) begin
            r_stb    <= 1'b0;
            r_busy   <= 1'b0;
            r_error  <= 1'b1;
            r_code   <= w_fail_code;
            r_digest <= '0;
            r_state  <= S_ERR;
          end else if (!r_stb) begin
            r_stb <= 1'b1;
            r_adr <= w_adr;
            r_we  <= w_we;
            r_dat <= w_dat;
            r_tmo <= '0;
          end else if (wbm_ack_i) begin
            r_stb <= 1'b0;
            case (r_state)
              S_ID_RD:  r_state <= S_RST_WR;
              S_RST_WR: begin r_state <= S_MSG_WR; r_idx <= '0; end
              S_MSG_WR: begin
                r_idx <= r_idx + 4'd1;
                if (r_idx == 4'd15) r_state <= S_POLL_RD;
              end
              S_POLL_RD: begin
                if (wbm_dat_i[3]) begin r_state <= S_DIG_RD; r_idx <= '0; end
                else r_polls <= r_polls + 1'b1;
              end
              S_DIG_RD: begin
                r_digest[r_idx[2:0]] <= wbm_dat_i;
                r_idx <= r_idx + 4'd1;
                if (r_idx == 4'd4) begin
                  r_state <= S_FIN;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                end
              end
              default: ;
            endcase
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign error_code = r_code;
  assign digest     = r_digest;
  assign wbm_cyc_o  = r_stb;
  assign wbm_stb_o  = r_stb;
  assign wbm_we_o   = r_we;
  assign wbm_sel_o  = 4'hF;
  assign wbm_adr_o  = r_adr;
  assign wbm_dat_o  = r_dat;

endmodule
